// File: rtl/regfile_wr_arb.sv
// regfile_wr_arb: merges pop-SP, write-back and debug writes onto the single register-file write port
// Ports: clk/rst (sync, active-high); wb_* write-back source; pop_* SP update from EX;
//   dbg_* held debug request with one-cycle dbg_ack; rf_* registered write port;
//   wb_stall/init_busy/q_count status; lk_reg/lk_hit/lk_data forwarding lookup.
// Build option: define RF_CLEAR_EN to zero every register except SP after the SP initialisation.
module regfile_wr_arb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int SP_ADDR = 29,
  parameter logic [DATA_W-1:0] SP_RESET = 32'h00000FFF,
  parameter int QDEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_we,
  input  logic [ADDR_W-1:0] wb_reg,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              pop_we,
  input  logic [DATA_W-1:0] pop_data,
  input  logic              dbg_req,
  input  logic [ADDR_W-1:0] dbg_reg,
  input  logic [DATA_W-1:0] dbg_data,
  output logic              dbg_ack,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_reg,
  output logic [DATA_W-1:0] rf_data,
  output logic              wb_stall,
  output logic              init_busy,
  output logic [2:0]        q_count,
  input  logic [ADDR_W-1:0] lk_reg,
  output logic              lk_hit,
  output logic [DATA_W-1:0] lk_data
);
  localparam int IW = (QDEPTH > 2) ? 2 : 1;
  localparam logic [ADDR_W-1:0] SP = ADDR_W'(SP_ADDR);
`ifdef RF_CLEAR_EN
  typedef enum logic [1:0] {INIT_SP, CLEAR, RUN} state_t;
  localparam logic [ADDR_W-1:0] FIRST = (SP == '0) ? ADDR_W'(1) : '0;
  localparam logic [ADDR_W-1:0] LAST = (SP == '1) ? ~ADDR_W'(1) : '1;
  logic [ADDR_W-1:0] clr_q, clr_d;
`else
  typedef enum logic {INIT_SP, RUN} state_t;
`endif
  state_t state_q, state_d;
  logic [ADDR_W-1:0] q_reg_q [QDEPTH];
  logic [ADDR_W-1:0] q_reg_d [QDEPTH];
  logic [DATA_W-1:0] q_data_q [QDEPTH];
  logic [DATA_W-1:0] q_data_d [QDEPTH];
  logic [2:0] count_q, count_d, n;
  logic rf_we_q, rf_we_d;
  logic [ADDR_W-1:0] rf_reg_q, rf_reg_d;
  logic [DATA_W-1:0] rf_data_q, rf_data_d;
  logic run, empty, wb_v, pop_g, deq, wb_g, dbg_g, enq;
  assign run = (state_q == RUN) & ~rst;
  assign init_busy = ~run;
  assign empty = count_q == '0;
  assign wb_stall = init_busy | (count_q == 3'(QDEPTH));
  assign wb_v = wb_we & ~wb_stall;
  assign pop_g = pop_we & ~wb_stall;
  assign deq = run & ~pop_g & ~empty;
  assign wb_g = wb_v & ~pop_g & empty;
  assign dbg_g = run & dbg_req & ~pop_we & ~wb_we & empty;
  // a write-back to SP that coincides with a pop is older than the pop and is dropped
  assign enq = wb_v & ~wb_g & ~(pop_g & (wb_reg == SP));
  assign dbg_ack = dbg_g;
  assign q_count = count_q;
  assign rf_we = rf_we_q;
  assign rf_reg = rf_reg_q;
  assign rf_data = rf_data_q;
  always_comb begin
    state_d = state_q;
    rf_we_d = 1'b1;
    rf_reg_d = rf_reg_q;
    rf_data_d = rf_data_q;
`ifdef RF_CLEAR_EN
    clr_d = clr_q;
`endif
    if (state_q == INIT_SP) begin
      rf_reg_d = SP;
      rf_data_d = SP_RESET;
`ifdef RF_CLEAR_EN
      state_d = CLEAR;
      clr_d = FIRST;
    end else if (state_q == CLEAR) begin
      rf_reg_d = clr_q;
      rf_data_d = '0;
      // step over SP so the clear issues one grant per cycle with no bubble
      clr_d = (clr_q + 1'b1 == SP) ? clr_q + 2'd2 : clr_q + 1'b1;
      state_d = (clr_q == LAST) ? RUN : CLEAR;
`else
      state_d = RUN;
`endif
    end else if (pop_g) begin
      rf_reg_d = SP;
      rf_data_d = pop_data;
    end else if (deq) begin
      rf_reg_d = q_reg_q[0];
      rf_data_d = q_data_q[0];
    end else if (wb_g) begin
      rf_reg_d = wb_reg;
      rf_data_d = wb_data;
    end else if (dbg_g) begin
      rf_reg_d = dbg_reg;
      rf_data_d = dbg_data;
    end else begin
      rf_we_d = 1'b0;
    end
  end
  // rebuild the queue packed from the head: drop the dequeued head and any SP entries a pop squashes
  always_comb begin
    n = '0;
    for (int i = 0; i < QDEPTH; i++) begin
      q_reg_d[i] = '0;
      q_data_d[i] = '0;
    end
    for (int i = 0; i < QDEPTH; i++)
      if ((3'(i) < count_q) && !(deq && i == 0) && !(pop_g && q_reg_q[i] == SP)) begin
        q_reg_d[IW'(n)] = q_reg_q[i];
        q_data_d[IW'(n)] = q_data_q[i];
        n = n + 3'd1;
      end
    if (enq) begin
      q_reg_d[IW'(n)] = wb_reg;
      q_data_d[IW'(n)] = wb_data;
      n = n + 3'd1;
    end
    count_d = n;
  end
  // later matches overwrite earlier ones, so the tail-most queue entry wins over the rf stage
  always_comb begin
    lk_hit = rf_we_q && (rf_reg_q == lk_reg);
    lk_data = lk_hit ? rf_data_q : '0;
    for (int i = 0; i < QDEPTH; i++)
      if ((3'(i) < count_q) && (q_reg_q[i] == lk_reg)) begin
        lk_hit = 1'b1;
        lk_data = q_data_q[i];
      end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= INIT_SP;
      count_q <= '0;
      rf_we_q <= 1'b0;
      rf_reg_q <= '0;
      rf_data_q <= '0;
      q_reg_q <= '{default: '0};
      q_data_q <= '{default: '0};
`ifdef RF_CLEAR_EN
      clr_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      rf_we_q <= rf_we_d;
      rf_reg_q <= rf_reg_d;
      rf_data_q <= rf_data_d;
      q_reg_q <= q_reg_d;
      q_data_q <= q_data_d;
`ifdef RF_CLEAR_EN
      clr_q <= clr_d;
`endif
    end
  end
endmodule

// File: tb/tb_regfile_wr_arb.sv
// tb_regfile_wr_arb: directed self-checking bench for regfile_wr_arb
module tb_regfile_wr_arb;
  logic clk = 1'b0;
  logic rst, wb_we, pop_we, dbg_req, dbg_ack, rf_we, wb_stall, init_busy, lk_hit;
  logic [4:0] wb_reg, dbg_reg, rf_reg, lk_reg;
  logic [31:0] wb_data, pop_data, dbg_data, rf_data, lk_data;
  logic [2:0] q_count;
  int errors = 0;
  int checks = 0;

  regfile_wr_arb dut (
    .clk(clk), .rst(rst), .wb_we(wb_we), .wb_reg(wb_reg), .wb_data(wb_data),
    .pop_we(pop_we), .pop_data(pop_data), .dbg_req(dbg_req), .dbg_reg(dbg_reg),
    .dbg_data(dbg_data), .dbg_ack(dbg_ack), .rf_we(rf_we), .rf_reg(rf_reg),
    .rf_data(rf_data), .wb_stall(wb_stall), .init_busy(init_busy), .q_count(q_count),
    .lk_reg(lk_reg), .lk_hit(lk_hit), .lk_data(lk_data)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    wb_we = 1'b0;
    pop_we = 1'b0;
    dbg_req = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    idle();
    tick();
    tick();
    checks++; if ({rf_we, rf_reg, rf_data, dbg_ack} !== 39'h0) begin errors++; $display("FAIL rst_outputs got=%h exp=0", {rf_we, rf_reg, rf_data, dbg_ack}); end
    checks++; if (q_count !== 3'd0) begin errors++; $display("FAIL rst_qcount got=%0d exp=0", q_count); end
    checks++; if ({init_busy, wb_stall} !== 2'b11) begin errors++; $display("FAIL rst_busy_stall got=%b exp=11", {init_busy, wb_stall}); end
    rst = 1'b0;
    #1;
    checks++; if (init_busy !== 1'b1) begin errors++; $display("FAIL init_busy_c0 got=%b exp=1", init_busy); end
    tick();
    checks++; if ({rf_we, rf_reg, rf_data} !== {1'b1, 5'd29, 32'h00000FFF}) begin errors++; $display("FAIL init_sp got=%h exp=%h", {rf_we, rf_reg, rf_data}, {1'b1, 5'd29, 32'h00000FFF}); end
`ifdef RF_CLEAR_EN
    checks++; if (init_busy !== 1'b1) begin errors++; $display("FAIL clr_busy_c1 got=%b exp=1", init_busy); end
    lk_reg = 5'd3;
    for (int k = 0; k < 31; k++) begin
      int idx;
      idx = (k < 29) ? k : k + 1;
      tick();
      checks++; if ({rf_we, rf_reg, rf_data} !== {1'b1, 5'(idx), 32'h0}) begin errors++; $display("FAIL clr_write k=%0d got=%h exp=%h", k, {rf_we, rf_reg, rf_data}, {1'b1, 5'(idx), 32'h0}); end
      checks++; if (init_busy !== (k < 30)) begin errors++; $display("FAIL clr_busy k=%0d got=%b exp=%b", k, init_busy, k < 30); end
      if (idx == 3) begin
        checks++; if ({lk_hit, lk_data} !== {1'b1, 32'h0}) begin errors++; $display("FAIL clr_fwd_r3 got=%h exp=%h", {lk_hit, lk_data}, {1'b1, 32'h0}); end
      end
    end
`else
    checks++; if (init_busy !== 1'b0) begin errors++; $display("FAIL init_busy_c1 got=%b exp=0", init_busy); end
`endif
    tick();
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL init_no_extra got=%b exp=0", rf_we); end
  endtask

  task automatic test_pop_wb;
    pop_we = 1'b1; pop_data = 32'h0FF0;
    wb_we = 1'b1; wb_reg = 5'd5; wb_data = 32'hAAAA;
    lk_reg = 5'd5;
    #1;
    checks++; if (wb_stall !== 1'b0) begin errors++; $display("FAIL pw_stall got=%b exp=0", wb_stall); end
    tick();
    idle();
    #1;
    checks++; if ({rf_we, rf_reg, rf_data} !== {1'b1, 5'd29, 32'h0FF0}) begin errors++; $display("FAIL pw_sp got=%h exp=%h", {rf_we, rf_reg, rf_data}, {1'b1, 5'd29, 32'h0FF0}); end
    checks++; if (q_count !== 3'd1) begin errors++; $display("FAIL pw_q1 got=%0d exp=1", q_count); end
    checks++; if ({lk_hit, lk_data} !== {1'b1, 32'hAAAA}) begin errors++; $display("FAIL pw_fwd got=%h exp=%h", {lk_hit, lk_data}, {1'b1, 32'hAAAA}); end
    tick();
    checks++; if ({rf_we, rf_reg, rf_data} !== {1'b1, 5'd5, 32'hAAAA}) begin errors++; $display("FAIL pw_r5 got=%h exp=%h", {rf_we, rf_reg, rf_data}, {1'b1, 5'd5, 32'hAAAA}); end
    checks++; if (q_count !== 3'd0) begin errors++; $display("FAIL pw_q0 got=%0d exp=0", q_count); end
    tick();
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL pw_idle got=%b exp=0", rf_we); end
    checks++; if ({lk_hit, lk_data} !== 33'h0) begin errors++; $display("FAIL pw_nohit got=%h exp=0", {lk_hit, lk_data}); end
  endtask

  task automatic test_squash;
    pop_we = 1'b1; pop_data = 32'h0100;
    wb_we = 1'b1; wb_reg = 5'd10; wb_data = 32'hA;
    tick();
    checks++; if ({rf_we, rf_reg, rf_data, q_count} !== {1'b1, 5'd29, 32'h0100, 3'd1}) begin errors++; $display("FAIL sq_c1 got=%h exp=%h", {rf_we, rf_reg, rf_data, q_count}, {1'b1, 5'd29, 32'h0100, 3'd1}); end
    pop_we = 1'b0;
    wb_reg = 5'd29; wb_data = 32'h1;
    lk_reg = 5'd29;
    tick();
    checks++; if ({rf_we, rf_reg, rf_data, q_count} !== {1'b1, 5'd10, 32'hA, 3'd1}) begin errors++; $display("FAIL sq_c2 got=%h exp=%h", {rf_we, rf_reg, rf_data, q_count}, {1'b1, 5'd10, 32'hA, 3'd1}); end
    checks++; if ({lk_hit, lk_data} !== {1'b1, 32'h1}) begin errors++; $display("FAIL sq_fwd_r29q got=%h exp=%h", {lk_hit, lk_data}, {1'b1, 32'h1}); end
    pop_we = 1'b1; pop_data = 32'h0FFC;
    wb_reg = 5'd3; wb_data = 32'h2;
    tick();
    idle();
    #1;
    checks++; if ({rf_we, rf_reg, rf_data} !== {1'b1, 5'd29, 32'h0FFC}) begin errors++; $display("FAIL sq_sp got=%h exp=%h", {rf_we, rf_reg, rf_data}, {1'b1, 5'd29, 32'h0FFC}); end
    checks++; if (q_count !== 3'd1) begin errors++; $display("FAIL sq_qcount got=%0d exp=1", q_count); end
    checks++; if ({lk_hit, lk_data} !== {1'b1, 32'h0FFC}) begin errors++; $display("FAIL sq_fwd_r29 got=%h exp=%h", {lk_hit, lk_data}, {1'b1, 32'h0FFC}); end
    lk_reg = 5'd3;
    #1;
    checks++; if ({lk_hit, lk_data} !== {1'b1, 32'h2}) begin errors++; $display("FAIL sq_fwd_r3 got=%h exp=%h", {lk_hit, lk_data}, {1'b1, 32'h2}); end
    tick();
    checks++; if ({rf_we, rf_reg, rf_data, q_count} !== {1'b1, 5'd3, 32'h2, 3'd0}) begin errors++; $display("FAIL sq_r3 got=%h exp=%h", {rf_we, rf_reg, rf_data, q_count}, {1'b1, 5'd3, 32'h2, 3'd0}); end
  endtask

  task automatic test_fill;
    pop_we = 1'b1; pop_data = 32'h0200;
    wb_we = 1'b1; wb_reg = 5'd1; wb_data = 32'h11;
    tick();
    checks++; if ({rf_we, rf_reg, rf_data, q_count} !== {1'b1, 5'd29, 32'h0200, 3'd1}) begin errors++; $display("FAIL fill_c1 got=%h exp=%h", {rf_we, rf_reg, rf_data, q_count}, {1'b1, 5'd29, 32'h0200, 3'd1}); end
    pop_data = 32'h0204;
    wb_reg = 5'd2; wb_data = 32'h22;
    tick();
    checks++; if ({rf_we, rf_reg, rf_data, q_count} !== {1'b1, 5'd29, 32'h0204, 3'd2}) begin errors++; $display("FAIL fill_c2 got=%h exp=%h", {rf_we, rf_reg, rf_data, q_count}, {1'b1, 5'd29, 32'h0204, 3'd2}); end
    pop_data = 32'h0208;
    wb_reg = 5'd2; wb_data = 32'h33;
    #1;
    checks++; if (wb_stall !== 1'b1) begin errors++; $display("FAIL fill_stall_full got=%b exp=1", wb_stall); end
    tick();
    checks++; if ({rf_we, rf_reg, rf_data, q_count} !== {1'b1, 5'd1, 32'h11, 3'd1}) begin errors++; $display("FAIL fill_c3 got=%h exp=%h", {rf_we, rf_reg, rf_data, q_count}, {1'b1, 5'd1, 32'h11, 3'd1}); end
    checks++; if (wb_stall !== 1'b0) begin errors++; $display("FAIL fill_stall_free got=%b exp=0", wb_stall); end
    tick();
    idle();
    lk_reg = 5'd2;
    #1;
    checks++; if ({rf_we, rf_reg, rf_data, q_count} !== {1'b1, 5'd29, 32'h0208, 3'd2}) begin errors++; $display("FAIL fill_c4 got=%h exp=%h", {rf_we, rf_reg, rf_data, q_count}, {1'b1, 5'd29, 32'h0208, 3'd2}); end
    checks++; if ({lk_hit, lk_data} !== {1'b1, 32'h33}) begin errors++; $display("FAIL fill_fwd_tail got=%h exp=%h", {lk_hit, lk_data}, {1'b1, 32'h33}); end
    tick();
    checks++; if ({rf_we, rf_reg, rf_data, q_count} !== {1'b1, 5'd2, 32'h22, 3'd1}) begin errors++; $display("FAIL fill_c5 got=%h exp=%h", {rf_we, rf_reg, rf_data, q_count}, {1'b1, 5'd2, 32'h22, 3'd1}); end
    checks++; if ({lk_hit, lk_data} !== {1'b1, 32'h33}) begin errors++; $display("FAIL fill_fwd_q_over_rf got=%h exp=%h", {lk_hit, lk_data}, {1'b1, 32'h33}); end
    tick();
    checks++; if ({rf_we, rf_reg, rf_data, q_count} !== {1'b1, 5'd2, 32'h33, 3'd0}) begin errors++; $display("FAIL fill_c6 got=%h exp=%h", {rf_we, rf_reg, rf_data, q_count}, {1'b1, 5'd2, 32'h33, 3'd0}); end
    tick();
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL fill_idle got=%b exp=0", rf_we); end
  endtask

  task automatic test_dbg;
    dbg_req = 1'b1; dbg_reg = 5'd7; dbg_data = 32'h1234;
    pop_we = 1'b1; pop_data = 32'h0300;
    wb_we = 1'b1; wb_reg = 5'd4; wb_data = 32'h44;
    #1;
    checks++; if (dbg_ack !== 1'b0) begin errors++; $display("FAIL dbg_busy_ack got=%b exp=0", dbg_ack); end
    tick();
    pop_we = 1'b0;
    wb_we = 1'b0;
    #1;
    checks++; if ({rf_we, rf_reg, rf_data} !== {1'b1, 5'd29, 32'h0300}) begin errors++; $display("FAIL dbg_c1 got=%h exp=%h", {rf_we, rf_reg, rf_data}, {1'b1, 5'd29, 32'h0300}); end
    checks++; if (dbg_ack !== 1'b0) begin errors++; $display("FAIL dbg_queue_ack got=%b exp=0", dbg_ack); end
    tick();
    checks++; if ({rf_we, rf_reg, rf_data} !== {1'b1, 5'd4, 32'h44}) begin errors++; $display("FAIL dbg_c2 got=%h exp=%h", {rf_we, rf_reg, rf_data}, {1'b1, 5'd4, 32'h44}); end
    checks++; if (dbg_ack !== 1'b1) begin errors++; $display("FAIL dbg_idle_ack got=%b exp=1", dbg_ack); end
    tick();
    dbg_req = 1'b0;
    #1;
    checks++; if ({rf_we, rf_reg, rf_data} !== {1'b1, 5'd7, 32'h1234}) begin errors++; $display("FAIL dbg_write got=%h exp=%h", {rf_we, rf_reg, rf_data}, {1'b1, 5'd7, 32'h1234}); end
    checks++; if (dbg_ack !== 1'b0) begin errors++; $display("FAIL dbg_ack_pulse got=%b exp=0", dbg_ack); end
    tick();
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL dbg_idle got=%b exp=0", rf_we); end
  endtask

  task automatic test_reset_mid;
    pop_we = 1'b1; pop_data = 32'h0400;
    wb_we = 1'b1; wb_reg = 5'd6; wb_data = 32'h66;
    tick();
    idle();
    checks++; if (q_count !== 3'd1) begin errors++; $display("FAIL mid_q1 got=%0d exp=1", q_count); end
    rst = 1'b1;
    tick();
    checks++; if ({q_count, rf_we, init_busy} !== {3'd0, 1'b0, 1'b1}) begin errors++; $display("FAIL mid_rst got=%b exp=%b", {q_count, rf_we, init_busy}, {3'd0, 1'b0, 1'b1}); end
    rst = 1'b0;
    for (int i = 0; i < 40 && init_busy; i++) tick();
    checks++; if (init_busy !== 1'b0) begin errors++; $display("FAIL mid_reinit_timeout got=%b exp=0", init_busy); end
    tick();
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL mid_discard got=%b exp=0", rf_we); end
  endtask

  initial begin
    rst = 1'b1;
    wb_we = 1'b0; wb_reg = '0; wb_data = '0;
    pop_we = 1'b0; pop_data = '0;
    dbg_req = 1'b0; dbg_reg = '0; dbg_data = '0;
    lk_reg = '0;
    test_reset();
    test_pop_wb();
    test_squash();
    test_fill();
    test_dbg();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/regfile_wr_arb.md
Name: regfile_wr_arb

Overview:
Write-port arbiter and sequencer for the 32x32 register file in the decode stage. It merges three write sources onto the single register-file write port and performs the post-reset stack-pointer initialisation. The sources are the write-back port, the pop stack-pointer update from EX, and a low-priority debug/loader port. Write-back writes that lose arbitration are held in a small ordered queue, which is also exposed to decode for forwarding.

Parameters:
DATA_W, 32, register data width
ADDR_W, 5, register index width
SP_ADDR, 29, stack-pointer register index
SP_RESET, 32'h00000FFF, stack-pointer value written after reset
QDEPTH, 2, deferred write-back queue depth (2..4)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
wb_we  in  1  write-back write request
wb_reg  in  ADDR_W  write-back destination
wb_data  in  DATA_W  write-back data
pop_we  in  1  pop SP update request (single-cycle pulse)
pop_data  in  DATA_W  new SP value
dbg_req  in  1  debug write request, held until ack
dbg_reg  in  ADDR_W  debug destination
dbg_data  in  DATA_W  debug data
dbg_ack  out  1  one-cycle grant pulse for debug
rf_we  out  1  register-file write enable (registered)
rf_reg  out  ADDR_W  register-file write index (registered)
rf_data  out  DATA_W  register-file write data (registered)
wb_stall  out  1  upstream must hold; wb_we and pop_we are ignored while high
init_busy  out  1  reset/initialisation in progress
q_count  out  3  valid queue entries
lk_reg  in  ADDR_W  forwarding lookup index
lk_hit  out  1  lk_reg has a pending write
lk_data  out  DATA_W  youngest pending data for lk_reg

Behaviour:
- Reset: while rst=1, all of the following hold:
  - rf_we=0, rf_reg=0, rf_data=0, dbg_ack=0.
  - Queue is emptied; q_count=0.
  - init_busy=1, wb_stall=1.
  - State goes to INIT_SP.
  - Reset asserted mid-operation discards queued writes.
- State machine: INIT_SP -> RUN. INIT_SP lasts exactly one cycle after rst falls.
  - In INIT_SP the arbiter registers {SP_ADDR, SP_RESET}, so rf_we=1 in the next cycle.
  - init_busy=1 in INIT_SP; init_busy=0 from RUN on.
- Latency: every grant appears on rf_* one cycle after the grant cycle. rf_we stays high for exactly one cycle per grant.
- RUN priority, at most one grant per cycle:
  1. pop_we
  2. queue head
  3. new wb_we
  4. dbg_req
- Queue ordering:
  - A new wb_we goes directly to the port only if the queue is empty and pop_we=0. Otherwise it is enqueued at the tail.
  - The queue drains in FIFO order.
- Same-cycle enqueue and dequeue: q_count is unchanged.
- Full queue: wb_stall = init_busy | (q_count==QDEPTH). wb_we or pop_we while wb_stall=1 is ignored, and the requester holds.
- SP ordering: pop is younger than any write-back.
  - On a pop grant, queued entries with reg==SP_ADDR are invalidated and removed; q_count drops accordingly.
  - A same-cycle wb_we to SP_ADDR is dropped.
- Debug grant: only when pop_we=0, wb_we=0 and the queue is empty. dbg_ack=1 in the grant cycle only.
- Forwarding (combinational):
  - Lookup covers valid queue entries plus the registered rf_* stage.
  - The youngest match wins, in the order queue tail > ... > head > rf_* stage.
  - lk_hit=0 gives lk_data=0.

Optional Feature:
RF_CLEAR_EN
- Defined: adds state CLEAR between INIT_SP and RUN.
  - CLEAR writes zero to indices 0..31 ascending, skipping SP_ADDR: 31 grants in 31 consecutive cycles.
  - init_busy and wb_stall stay high through CLEAR.
  - RUN starts after the last index.
- Undefined: INIT_SP -> RUN directly. The CLEAR state and its counter are not built.

Test Plan:
- Release rst at cycle 0 -> rf_we=1, rf_reg=29, rf_data=0x00000FFF at cycle 1. init_busy=0 from cycle 1. No other write follows.
- In RUN, pop_we (0x0FF0) and wb_we (r5=0xAAAA) in the same cycle with an empty queue -> SP write next cycle, r5 write the cycle after. q_count goes 1 then 0.
- Queue holds {r29=0x1, r3=0x2}; pop_we (0x0FFC) arrives -> r29 entry squashed, q_count=1. Outputs are SP=0x0FFC, then r3=0x2.
- Fill queue to QDEPTH=2 while pop_we is high for 3 cycles -> wb_stall=1, held wb_we not lost. After pops stop, 3 write-backs issue in order.
- dbg_req (r7=0x1234) held while wb traffic is present -> dbg_ack only in the first idle cycle with an empty queue. r7 written next cycle.
- With RF_CLEAR_EN: after rst release -> SP write, then 31 zero writes skipping r29. init_busy high for 32 cycles. lk_reg=3 hits with lk_data=0 while r3 is in the rf_* stage.
